bsg_cgol_output_serializer: RTL and testbench

//  Downstream neighbour of the CGoL controller and cell array. Takes the final

---
 rtl/bsg_cgol_output_serializer.sv | 83 ++++++++
 tb/tb_bsg_cgol_output_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cgol_output_serializer.sv
// bsg_cgol_output_serializer
//   Captures a finished CGoL board from the controller/cell array and streams
//   it out as width_p-bit words over a valid/yumi channel, LSB (row 0) first.
//   The capture is acknowledged with a single-cycle yumi_o, so the controller
//   is free as soon as the board is latched.
// Ports
//   clk_i    : clock, all state on posedge
//   reset_i  : asynchronous active-high reset
//   data_i   : board, bit r*board_width_p+c = cell (r,c)
//   v_i      : board valid from controller
//   yumi_o   : board consumed (combinational, only asserted in idle)
//   data_o   : current output word
//   last_o   : data_o is the final word of the board
//   v_o      : output word valid
//   yumi_i   : downstream consumes data_o this cycle
module bsg_cgol_output_serializer #(
  parameter int board_width_p = 64,
  parameter int width_p       = 32
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [board_width_p*board_width_p-1:0]   data_i,
  input  logic                                     v_i,
  output logic                                     yumi_o,
  output logic [width_p-1:0]                       data_o,
  output logic                                     last_o,
  output logic                                     v_o,
  input  logic                                     yumi_i
);

  localparam int board_bits_lp = board_width_p * board_width_p;
  localparam int num_words_lp  = (board_bits_lp + width_p - 1) / width_p;
  localparam int buf_bits_lp   = num_words_lp * width_p;
  localparam int cnt_width_lp  = (num_words_lp > 1) ? $clog2(num_words_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_words_lp - 1);

  typedef enum logic {eIDLE, eSEND} state_e;

  state_e                  state_r;
  logic [cnt_width_lp-1:0] count_r;
  logic [buf_bits_lp-1:0]  shift_r;
  logic                    last_word;

  assign last_word = (count_r == last_cnt_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eIDLE;
      count_r <= '0;
      shift_r <= '0;
    end else begin
      case (state_r)
        eIDLE: begin
          if (v_i) begin
            // Zero-extension makes the padding bits of the final word read 0.
            shift_r <= buf_bits_lp'(data_i);
            count_r <= '0;
            state_r <= eSEND;
          end
        end
        eSEND: begin
          if (yumi_i) begin
            // After the final shift the register is all zero, so data_o
            // reads 0 whenever idle.
            shift_r <= shift_r >> width_p;
            if (last_word) begin
              state_r <= eIDLE;
            end else begin
              count_r <= count_r + cnt_width_lp'(1);
            end
          end
        end
        default: state_r <= eIDLE;
      endcase
    end
  end

  assign yumi_o = (state_r == eIDLE) && v_i;
  assign v_o    = (state_r == eSEND);
  assign last_o = (state_r == eSEND) && last_word;
  assign data_o = shift_r[width_p-1:0];

endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
module tb_bsg_cgol_output_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 4x4 board, 8-bit words (two words per board)
  logic [15:0] data_a = '0;
  logic        v_drv_a = 1'b0;
  logic        yumi_in_a = 1'b0;
  logic        yumi_a, last_a, vo_a;
  logic [7:0]  dout_a;
  logic        v_a;

  // Tiny controller stand-in: holds v until yumi, then returns to WAIT
  logic ctrl_mode = 1'b0;
  logic ctrl_start = 1'b0;
  logic ctrl_v;
  assign v_a = ctrl_mode ? ctrl_v : v_drv_a;

  always @(posedge clk or posedge rst) begin
    if (rst) ctrl_v <= 1'b0;
    else if (ctrl_start) ctrl_v <= 1'b1;
    else if (ctrl_v && yumi_a) ctrl_v <= 1'b0;
  end

  bsg_cgol_output_serializer #(.board_width_p(4), .width_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .data_i(data_a), .v_i(v_a), .yumi_o(yumi_a),
    .data_o(dout_a), .last_o(last_a), .v_o(vo_a), .yumi_i(yumi_in_a)
  );

  // Instance B: 3x3 board, 4-bit words (three words, 3 padding bits)
  logic [8:0] data_b = '0;
  logic       v_b = 1'b0;
  logic       yumi_in_b = 1'b0;
  logic       yumi_b, last_b, vo_b;
  logic [3:0] dout_b;

  bsg_cgol_output_serializer #(.board_width_p(3), .width_p(4)) dut_pad (
    .clk_i(clk), .reset_i(rst), .data_i(data_b), .v_i(v_b), .yumi_o(yumi_b),
    .data_o(dout_b), .last_o(last_b), .v_o(vo_b), .yumi_i(yumi_in_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model for instance A: a board becomes a queue of words
  bit         m_busy = 0;
  logic [7:0] m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_q.delete();
    end else if (!m_busy) begin
      if (v_a) begin
        for (int k = 0; k < 2; k++) m_q.push_back(8'((data_a >> (k * 8)) & 16'hFF));
        m_busy = 1;
      end
    end else if (yumi_in_a) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_busy = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_v_o", 32'(vo_a), 32'(m_busy));
    chk("model_data_o", 32'(dout_a), m_busy ? 32'(m_q[0]) : 32'h0);
    chk("model_last_o", 32'(last_a), 32'(m_busy && m_q.size() == 1));
    chk("model_yumi_o", 32'(yumi_a), 32'(!m_busy && v_a));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (vo_a && n < 20) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(vo_a), 32'h0);
  endtask

  int v_hist[7];
  int y_hist[7];
  int pulses, bubbles;

  initial begin
    // Reset state
    #2;
    chk("reset_v_o", 32'(vo_a), 0);
    chk("reset_data_o", 32'(dout_a), 0);
    chk("reset_last_o", 32'(last_a), 0);
    chk("reset_yumi_o", 32'(yumi_a), 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: basic two-word board
    data_a = 16'hA5C3; v_drv_a = 1'b1; yumi_in_a = 1'b1;
    #1 chk("t1_yumi_o", 32'(yumi_a), 1);
    step();
    v_drv_a = 1'b0;
    #1;
    chk("t1_w0", 32'(dout_a), 32'hC3);
    chk("t1_w0_last", 32'(last_a), 0);
    chk("t1_yumi_off", 32'(yumi_a), 0);
    step();
    chk("t1_w1", 32'(dout_a), 32'hA5);
    chk("t1_w1_last", 32'(last_a), 1);
    step();
    chk("t1_done", 32'(vo_a), 0);

    // 2: backpressure holds word 0
    yumi_in_a = 1'b0; v_drv_a = 1'b1;
    step();
    v_drv_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_data", 32'(dout_a), 32'hC3);
      chk("t2_hold_last", 32'(last_a), 0);
      chk("t2_hold_v", 32'(vo_a), 1);
      step();
    end
    yumi_in_a = 1'b1;
    step();
    chk("t2_w1", 32'(dout_a), 32'hA5);
    wait_idle_a("t2");

    // 4: v_i held, boards A then B, one idle bubble between them
    data_a = 16'hBEEF; v_drv_a = 1'b1; yumi_in_a = 1'b1;
    #1;
    v_hist[0] = int'(vo_a); y_hist[0] = int'(yumi_a);
    for (int i = 1; i < 7; i++) begin
      step();
      if (i == 1) data_a = 16'h0F0F;
      if (i == 4) v_drv_a = 1'b0;
      #1;
      v_hist[i] = int'(vo_a); y_hist[i] = int'(yumi_a);
    end
    pulses = 0; bubbles = 0;
    for (int i = 0; i < 7; i++) pulses += y_hist[i];
    for (int i = 1; i < 4; i++) bubbles += (v_hist[i] == 0) ? 1 : 0;
    chk("t4_yumi_pulses", 32'(pulses), 2);
    chk("t4_bubble", 32'(bubbles), 1);
    chk("t4_bubble_pos", 32'(v_hist[3]), 0);
    wait_idle_a("t4");

    // 5: reset between edges after word 0
    data_a = 16'h5A5A; v_drv_a = 1'b1; yumi_in_a = 1'b1;
    step();
    v_drv_a = 1'b0;
    step();
    chk("t5_w1_before_rst", 32'(dout_a), 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk("t5_v_drop", 32'(vo_a), 0);
    chk("t5_data_clr", 32'(dout_a), 0);
    step();
    rst = 1'b0;
    data_a = 16'h1234; v_drv_a = 1'b1;
    step();
    v_drv_a = 1'b0;
    #1;
    chk("t5_fresh_w0", 32'(dout_a), 32'h34);
    chk("t5_fresh_last", 32'(last_a), 0);
    wait_idle_a("t5");

    // 6: controller integration, three frames
    ctrl_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      data_a = 16'(16'h1111 * (f + 1));
      ctrl_start = 1'b1;
      step();
      ctrl_start = 1'b0;
      #1;
      chk("t6_yumi_to_ctrl", 32'(yumi_a), 1);
      step();
      chk("t6_ctrl_wait", 32'(ctrl_v), 0);
      chk("t6_still_sending", 32'(vo_a), 1);
      wait_idle_a("t6");
    end
    ctrl_mode = 1'b0;

    // 3: padding on the 3x3 / 4-bit instance
    data_b = 9'h1FF; v_b = 1'b1; yumi_in_b = 1'b1;
    step();
    v_b = 1'b0;
    chk("t3_w0", 32'(dout_b), 32'hF);
    chk("t3_w0_last", 32'(last_b), 0);
    step();
    chk("t3_w1", 32'(dout_b), 32'hF);
    chk("t3_w1_last", 32'(last_b), 0);
    step();
    chk("t3_w2", 32'(dout_b), 32'h1);
    chk("t3_w2_last", 32'(last_b), 1);
    chk("t3_w2_v", 32'(vo_b), 1);
    step();
    chk("t3_done", 32'(vo_b), 0);

    // yumi_i while idle is ignored
    yumi_in_b = 1'b1;
    step(); step();
    chk("idle_yumi_ignored", 32'(vo_b), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
